// File: rtl/receiver_core_pkg.sv
// Shared UART frame definitions: FSM states, default line rate, oversampling, idle level.
// Shared with transmitter_core so both ends agree on the frame format.
package receiver_core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } rx_state_e;

    localparam logic [31:0] DEF_BAUDRATE   = 32'd9600;
    localparam logic [31:0] DEF_FREQUENCY  = 32'd100000000;
    localparam int unsigned DEF_OVERSAMPLE = 16;
    localparam logic        LINE_IDLE      = 1'b1;

    // 2-of-3 majority used by the glitch-rejecting sampler
    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/receiver_core_tick.sv
// Free-running oversample tick: one-clk pulse every frequency/(baudrate*oversample) clks.
module rx_baudrate_tick_generator #(
    parameter logic [31:0] baudrate   = 32'd9600,
    parameter logic [31:0] frequency  = 32'd100000000,
    parameter int unsigned oversample = 16
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam logic [31:0] DIVISOR = frequency / (baudrate * oversample);
    localparam int unsigned CW      = (DIVISOR > 32'd1) ? $clog2(DIVISOR) : 1;

    if (DIVISOR < 32'd1) begin : g_bad_divisor
        $error("rx_baudrate_tick_generator: frequency too low for baudrate*oversample");
    end

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else if (cnt == CW'(DIVISOR - 32'd1)) begin
            cnt  <= '0;
            tick <= 1'b1;
        end else begin
            cnt  <= cnt + CW'(1);
            tick <= 1'b0;
        end
    end

endmodule

// File: rtl/receiver_core.sv
// UART 8N1-style receiver with 16x oversampling and mid-bit sampling.
// Optional RX_MAJORITY_VOTE_EN: 2-of-3 vote around mid-bit, decision one tick later.
module receiver_core
    import receiver_core_pkg::*;
#(
    parameter int unsigned NO_OF_DATABITS = 8,
    parameter int unsigned NO_OF_STOPBITS = 1,
    parameter logic [31:0] BAUDRATE       = DEF_BAUDRATE,
    parameter logic [31:0] FREQUENCY      = DEF_FREQUENCY,
    parameter int unsigned OVERSAMPLE     = DEF_OVERSAMPLE
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic [NO_OF_DATABITS-1:0] data_out,
    output logic                      data_valid,
    output logic                      framing_error,
    output logic                      busy
);

    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(NO_OF_DATABITS);
    localparam logic [TW-1:0] DATA_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DBIT_LAST = BW'(NO_OF_DATABITS - 1);
    localparam logic [BW-1:0] SBIT_LAST = BW'(NO_OF_STOPBITS - 1);

    if (OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0) begin : g_bad_os
        $error("receiver_core: OVERSAMPLE must be even and >= 8");
    end
    if (NO_OF_DATABITS < 5 || NO_OF_DATABITS > 9) begin : g_bad_db
        $error("receiver_core: NO_OF_DATABITS must be 5..9");
    end
    if (NO_OF_STOPBITS < 1 || NO_OF_STOPBITS > 2) begin : g_bad_sb
        $error("receiver_core: NO_OF_STOPBITS must be 1 or 2");
    end

    logic tick;

    rx_baudrate_tick_generator #(
        .baudrate   (BAUDRATE),
        .frequency  (FREQUENCY),
        .oversample (OVERSAMPLE)
    ) u_tick (
        .clk     (clk),
        .reset_n (reset_n),
        .tick    (tick)
    );

    logic rx_m, rx_s;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_m <= LINE_IDLE;
            rx_s <= LINE_IDLE;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    logic sample_c;

`ifdef RX_MAJORITY_VOTE_EN
    // Start decision moves one tick later so every data/stop vote window ends at DATA_LAST
    localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2);
    logic [1:0] hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hist <= {2{LINE_IDLE}};
        end else if (tick) begin
            hist <= {hist[0], rx_s};
        end
    end

    assign sample_c = maj3(hist[1], hist[0], rx_s);
`else
    localparam logic [TW-1:0] START_LAST = TW'(OVERSAMPLE / 2 - 1);
    assign sample_c = rx_s;
`endif

    rx_state_e                 state;
    logic [TW-1:0]             tick_cnt;
    logic [BW-1:0]             bit_cnt;
    logic [NO_OF_DATABITS-1:0] shift_reg;
    logic                      err;
    logic                      wait_high;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            tick_cnt      <= '0;
            bit_cnt       <= '0;
            shift_reg     <= '0;
            err           <= 1'b0;
            wait_high     <= 1'b0;
            data_out      <= '0;
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            busy          <= 1'b0;
        end else begin
            data_valid    <= 1'b0;
            framing_error <= 1'b0;
            if (tick) begin
                case (state)
                    IDLE: begin
                        // After a frame ending low (break), re-arm only once the line is seen high
                        if (wait_high) begin
                            if (rx_s) wait_high <= 1'b0;
                        end else if (!rx_s) begin
                            state    <= START;
                            tick_cnt <= '0;
                            busy     <= 1'b1;
                        end
                    end
                    START: begin
                        if (tick_cnt == START_LAST) begin
                            tick_cnt <= '0;
                            bit_cnt  <= '0;
                            if (sample_c) begin
                                state <= IDLE;
                                busy  <= 1'b0;
                            end else begin
                                state <= DATA;
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    DATA: begin
                        if (tick_cnt == DATA_LAST) begin
                            tick_cnt  <= '0;
                            shift_reg <= {sample_c, shift_reg[NO_OF_DATABITS-1:1]};
                            if (bit_cnt == DBIT_LAST) begin
                                bit_cnt <= '0;
                                state   <= STOP;
                            end else begin
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    STOP: begin
                        if (tick_cnt == DATA_LAST) begin
                            tick_cnt <= '0;
                            if (bit_cnt == SBIT_LAST) begin
                                bit_cnt       <= '0;
                                data_out      <= shift_reg;
                                data_valid    <= 1'b1;
                                framing_error <= err | ~sample_c;
                                err           <= 1'b0;
                                wait_high     <= ~sample_c;
                                busy          <= 1'b0;
                                state         <= IDLE;
                            end else begin
                                err     <= err | ~sample_c;
                                bit_cnt <= bit_cnt + BW'(1);
                            end
                        end else begin
                            tick_cnt <= tick_cnt + TW'(1);
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_receiver_core.sv
// Scoreboard bench for receiver_core at FREQUENCY=1600, BAUDRATE=100 (tick every clk, 16 clk/bit).
module tb_receiver_core;

    typedef struct packed {
        logic [7:0] data;
        logic       ferr;
    } exp_t;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] data_out;
    logic       data_valid;
    logic       framing_error;
    logic       busy;

    int   n_vec;
    int   n_err;
    exp_t exp_q[$];
    logic prev_dv;

    receiver_core #(
        .NO_OF_DATABITS (8),
        .NO_OF_STOPBITS (1),
        .BAUDRATE       (32'd100),
        .FREQUENCY      (32'd1600),
        .OVERSAMPLE     (16)
    ) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx            (rx),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .framing_error (framing_error),
        .busy          (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every strobe pops one expected frame
    always @(negedge clk) begin
        exp_t e;
        if (framing_error && !data_valid) begin
            n_err++;
            $display("FAIL ferr_without_valid: framing_error=1 data_valid=0");
        end
        if (data_valid) begin
            n_vec++;
            if (prev_dv) begin
                n_err++;
                $display("FAIL strobe_width: data_valid high on consecutive cycles");
            end
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_strobe: data_out=%02h ferr=%0b", data_out, framing_error);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e.data || framing_error !== e.ferr)
                begin
                    n_err++;
                    $display("FAIL frame: got data=%02h ferr=%0b expected data=%02h ferr=%0b",
                             data_out, framing_error, e.data, e.ferr);
                end
            end
        end
        prev_dv = data_valid;
    end

    // Drive one bit period (16 clk), starting #1 after a rising edge
    task automatic send_bit(input logic v);
        rx = v;
        repeat (16) @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        exp_t e;
        e.data = d;
        e.ferr = ~stop;
        exp_q.push_back(e);
        send_bit(1'b0);
        check("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        n_vec   = 0;
        n_err   = 0;
        prev_dv = 1'b0;
        rx      = 1'b1;
        reset_n = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        check("rst_data_out", 32'(data_out), 32'd0);
        check("rst_data_valid", 32'(data_valid), 32'd0);
        check("rst_framing_error", 32'(framing_error), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset_n = 1'b1;
        idle(10);

        // Single frame
        send_frame(8'hA5, 1'b1);
        idle(4);
        check("a5_drained", 32'(exp_q.size()), 32'd0);
        check("a5_busy_after", 32'(busy), 32'd0);
        check("a5_valid_after", 32'(data_valid), 32'd0);
        check("a5_data_held", 32'(data_out), 32'hA5);

        // Back-to-back, no idle gap
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        idle(4);
        check("b2b_drained", 32'(exp_q.size()), 32'd0);

        // Stop bit forced low
        send_frame(8'h3C, 1'b0);
        idle(20);
        check("ferr_drained", 32'(exp_q.size()), 32'd0);
        check("ferr_busy_after", 32'(busy), 32'd0);

        // Reset mid data bit 4 of 5A
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'(8'h5A >> i));
        rx = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("busy_before_abort", 32'(busy), 32'd1);
        reset_n = 1'b0;
        #1;
        check("abort_data_out", 32'(data_out), 32'd0);
        check("abort_data_valid", 32'(data_valid), 32'd0);
        check("abort_framing_error", 32'(framing_error), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle(20);
        send_frame(8'h81, 1'b1);
        idle(4);
        check("after_reset_drained", 32'(exp_q.size()), 32'd0);

        // 5-clk low glitch: false start
        rx = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("glitch_busy_start", 32'(busy), 32'd1);
        idle(30);
        check("glitch_busy_end", 32'(busy), 32'd0);

        // Break: 20 bit times low gives exactly one errored frame
        e.data = 8'h00;
        e.ferr = 1'b1;
        exp_q.push_back(e);
        rx = 1'b0;
        repeat (320) @(posedge clk);
        #1;
        idle(40);
        check("break_drained", 32'(exp_q.size()), 32'd0);
        check("break_busy_after", 32'(busy), 32'd0);

        // 1-clk high glitch at mid of data bit 2 of 8'h00
`ifdef RX_MAJORITY_VOTE_EN
        e.data = 8'h00;
`else
        e.data = 8'h04;
`endif
        e.ferr = 1'b0;
        exp_q.push_back(e);
        send_bit(1'b0);
        send_bit(1'b0);
        send_bit(1'b0);
        rx = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        rx = 1'b1;
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        for (int i = 3; i < 8; i++) send_bit(1'b0);
        send_bit(1'b1);
        idle(4);
        check("vote_drained", 32'(exp_q.size()), 32'd0);

        idle(10);
        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/receiver_core.md
Name: receiver_core

Overview:
- UART serial receiver: deserialises an asynchronous 8N1 stream on `rx` into parallel bytes, with a one-cycle `data_valid` strobe.
- Serial receive half paired with `transmitter_core`; shares its frame format: start bit 0, LSB-first data, stop bit(s) 1, idle 1.
- Sits between the board RX pin and the byte sink (image/weight loader for the handwriting NN).
- Uses 16x oversampling and mid-bit sampling to tolerate baud skew.

Parameters:
- NO_OF_DATABITS, 8, data bits per frame (5..9).
- NO_OF_STOPBITS, 1, stop bits checked per frame (1 or 2).
- BAUDRATE, 32'd9600, line rate in bits/s.
- FREQUENCY, 32'd100000000, clk frequency in Hz.
- OVERSAMPLE, 16, ticks per bit; must be even, >= 8.

Ports:
- clk  input  1  system clock, rising edge.
- reset_n  input  1  asynchronous, active-low reset.
- rx  input  1  asynchronous serial line, idle high.
- data_out  output  NO_OF_DATABITS  last received word; held until the next frame completes.
- data_valid  output  1  one-clk pulse when data_out updates.
- framing_error  output  1  one-clk pulse, coincident with data_valid, if any stop bit sampled 0.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset (async, reset_n=0):
  - state=IDLE, tick_cnt=0, bit_cnt=0, shift_reg=0.
  - data_out=0, data_valid=0, framing_error=0, busy=0.
  - Synchroniser flops preset to 1.
  - Deassertion takes effect on the next clk edge.
- Input conditioning: `rx` passes through a 2-flop synchroniser (rx_s). All decisions use rx_s, adding 2 clk of latency.
- Tick generator:
  - Divisor D = FREQUENCY/(BAUDRATE*OVERSAMPLE), integer truncation; D=651 at defaults.
  - Free-running; `tick` is high for one clk every D clks.
  - D < 1 is illegal and must trigger an elaboration error.
- FSM states: IDLE, START, DATA, STOP. All transitions are evaluated only on clks with tick=1.
  - IDLE:
    - rx_s=0 on a tick -> START, tick_cnt=0, busy=1 on the next clk.
  - START:
    - tick_cnt counts 0..OVERSAMPLE/2-1.
    - At tick_cnt=OVERSAMPLE/2-1 (mid start bit), sample rx_s.
    - 1 -> false start, back to IDLE, busy=0, no strobe.
    - 0 -> DATA, tick_cnt=0, bit_cnt=0.
  - DATA:
    - Sample at tick_cnt=OVERSAMPLE-1 (mid-bit); shift right: shift_reg <= {sample, shift_reg[N-1:1]}, LSB first.
    - After bit_cnt=NO_OF_DATABITS-1 -> STOP, bit_cnt=0.
  - STOP:
    - Sample each stop bit at tick_cnt=OVERSAMPLE-1; OR any 0 sample into err.
    - After the last stop bit, on the next clk: data_out<=shift_reg, data_valid=1, framing_error=err, busy=0, state=IDLE.
- Latency: data_valid rises 1 clk after the mid-last-stop-bit sample, i.e. about (1+N+STOP-0.5) bit times plus 3 clk after the falling start edge.
- Boundary conditions:
  - A frame with framing_error still updates data_out and pulses data_valid. The sink decides whether to drop it.
  - Back-to-back frames: a start edge may be detected on the first tick after return to IDLE. No dead cycles beyond that.
  - Line held low (break): each break yields a frame with framing_error=1, then IDLE re-arms only after rx_s is seen high. Add a `wait_high` flag in IDLE.
  - No receive buffer. An unconsumed data_out is overwritten by the next frame; no overrun flag.
  - reset_n asserted mid-frame aborts immediately; the partial frame is discarded with no strobe.
  - Counter wrap: tick_cnt is sized clog2(OVERSAMPLE) and resets to 0 at each bit boundary. It never free-wraps.

Optional Feature:
- Macro RX_MAJORITY_VOTE_EN.
- When defined: every sample (start, data, stop) is the 2-of-3 majority of rx_s at ticks mid-1, mid, mid+1. The decision is taken at mid+1, one tick later than without the macro, and all state timing shifts accordingly. Rejects single-tick glitches.
- When undefined: single sample at mid. No extra flops.
- Ports are identical in both builds.

Decomposition:
- Shared package/include `uart_defs.vh`:
  - frame state localparams (IDLE/START/DATA/STOP);
  - default BAUDRATE/FREQUENCY;
  - OVERSAMPLE;
  - line idle level.
  - `transmitter_core` shares the frame constants.
- Sub-module `rx_baudrate_tick_generator` (parameters baudrate, frequency, oversample; ports clk, reset_n, tick). It mirrors the transmitter's tick generator but is free-running and scaled by oversample.

Test Plan (bench overrides FREQUENCY=1600, BAUDRATE=100 -> D=1, bit = 16 clk):
- Send 8'hA5 with 1 stop bit -> data_out=8'hA5, data_valid one clk, framing_error=0, busy low after strobe.
- Send 8'h00 then 8'hFF back-to-back, no idle gap -> two strobes, data_out 00 then FF, no error.
- Send 8'h3C with stop bit forced 0 -> data_valid=1 and framing_error=1 same clk, data_out=8'h3C.
- rx low for 5 clk only (glitch shorter than half bit) -> no strobe, busy returns 0, FSM in IDLE.
- Assert reset_n=0 mid data bit 4 of 8'h5A -> all outputs 0 immediately. After release, a fresh 8'h81 frame is received correctly.
- With RX_MAJORITY_VOTE_EN: 1-clk high glitch at mid of data bit 2 of 8'h00 -> data_out=8'h00. Without the macro (glitch on the sampled clk) -> 8'h04.
